// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle for the hazard controller: ID/EX operand fields in,
// PC / IF/ID / ID/EX control strobes and stall statistics out.
interface hazard_ctrl_if #(
   parameter int unsigned CNT_W = 16
);
   logic [4:0]       ifid_rs;
   logic [4:0]       ifid_rt;
   logic             ifid_use_rs;
   logic             ifid_use_rt;
   logic             ifid_md_use;
   logic [4:0]       idex_rt;
   logic             idex_memtoreg;
   logic             md_start;
   logic             ex_redirect;
   logic             pc_stall_en;
   logic             ifid_wr;
   logic             idex_clear;
   logic             ifid_flush;
   logic             md_busy;
   logic [CNT_W-1:0] stall_count;

   modport master (
      output ifid_rs, ifid_rt, ifid_use_rs, ifid_use_rt, ifid_md_use,
             idex_rt, idex_memtoreg, md_start, ex_redirect,
      input  pc_stall_en, ifid_wr, idex_clear, ifid_flush, md_busy, stall_count
   );

   modport slave (
      input  ifid_rs, ifid_rt, ifid_use_rs, ifid_use_rt, ifid_md_use,
             idex_rt, idex_memtoreg, md_start, ex_redirect,
      output pc_stall_en, ifid_wr, idex_clear, ifid_flush, md_busy, stall_count
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Sequential load-use / mult-div interlock with redirect flushing and a
// saturating stall-cycle counter for the 5-stage MIPS pipeline.
module hazard_ctrl #(
   parameter int unsigned LOAD_LAT = 1,
   parameter int unsigned MD_LAT   = 4,
   parameter int unsigned CNT_W    = 16
) (
   input logic           clk,
   input logic           rst_n,
   hazard_ctrl_if.slave  hz
);

   typedef enum logic {RUN, LSTALL} state_t;

   localparam logic [2:0] LD_RELOAD = 3'(LOAD_LAT - 1);
   localparam logic [5:0] MD_RELOAD = 6'(MD_LAT);

   state_t           state, state_nx;
   logic [2:0]       ld_cnt, ld_cnt_nx;
   logic [5:0]       md_cnt;
   logic [CNT_W-1:0] stall_cnt;
   logic             load_hit;
   logic             md_busy;
   logic             md_hit;
   logic             stall;

   // $0 is hardwired zero, so a load "to" it never creates a dependency.
   always_comb begin
      load_hit = hz.idex_memtoreg && (hz.idex_rt != 5'd0) &&
                 ((hz.ifid_use_rs && (hz.ifid_rs == hz.idex_rt)) ||
                  (hz.ifid_use_rt && (hz.ifid_rt == hz.idex_rt)));
      md_busy  = (md_cnt != 6'd0);
      md_hit   = hz.ifid_md_use && md_busy;
      stall    = ((state == LSTALL) || load_hit || md_hit) && !hz.ex_redirect;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= RUN;
         ld_cnt <= '0;
      end else begin
         state  <= state_nx;
         ld_cnt <= ld_cnt_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      ld_cnt_nx = ld_cnt;
      if (hz.ex_redirect) begin
         state_nx  = RUN;
         ld_cnt_nx = '0;
      end else begin
         case (state)
            RUN: begin
               // First stall cycle is spent here; LSTALL covers the remaining LOAD_LAT-1.
               if (load_hit && (LOAD_LAT > 1)) begin
                  state_nx  = LSTALL;
                  ld_cnt_nx = LD_RELOAD;
               end
            end
            LSTALL: begin
               ld_cnt_nx = ld_cnt - 3'd1;
               if (ld_cnt == 3'd1) state_nx = RUN;
            end
            default: begin
               state_nx  = RUN;
               ld_cnt_nx = '0;
            end
         endcase
      end
   end

   always_comb begin
      hz.pc_stall_en = stall;
      hz.ifid_wr     = !stall;
      hz.idex_clear  = stall || hz.ex_redirect;
      hz.ifid_flush  = hz.ex_redirect;
      hz.md_busy     = md_busy;
      hz.stall_count = stall_cnt;
   end

   // The in-flight mult/div is older than any redirect, so only md_start and time affect it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         md_cnt <= '0;
      end else if (hz.md_start) begin
         md_cnt <= MD_RELOAD;
      end else if (md_busy) begin
         md_cnt <= md_cnt - 6'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (stall && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench: two hazard_ctrl instances (LOAD_LAT=3/CNT_W=4 and
// LOAD_LAT=1/CNT_W=16) driven with hand-computed directed vectors.
module tb_hazard_ctrl;

   // Control tuple ordering: {pc_stall_en, ifid_wr, idex_clear, ifid_flush, md_busy}
   localparam logic [4:0] C_RUN  = 5'b01000;
   localparam logic [4:0] C_RUNB = 5'b01001;
   localparam logic [4:0] C_STL  = 5'b10100;
   localparam logic [4:0] C_STLB = 5'b10101;
   localparam logic [4:0] C_RDR  = 5'b01110;
   localparam logic [4:0] C_RDRB = 5'b01111;

   typedef struct {
      bit          sel;
      int unsigned id;
      logic [4:0]  ctl;
      int unsigned cnt;
   } exp_t;

   logic clk;
   logic rst_n;
   exp_t q[$];
   int   checks;
   int   errors;
   int unsigned vid;

   hazard_ctrl_if #(.CNT_W(4))  ifa ();
   hazard_ctrl_if #(.CNT_W(16)) ifb ();

   hazard_ctrl #(.LOAD_LAT(3), .MD_LAT(4), .CNT_W(4)) u_a (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (ifa.slave)
   );

   hazard_ctrl #(.LOAD_LAT(1), .MD_LAT(4), .CNT_W(16)) u_b (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (ifb.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive_a(input logic [4:0] rs, rt, input logic urs, urt, mdu,
                          input logic [4:0] xrt, input logic mem, mds, rdr);
      ifa.ifid_rs = rs;  ifa.ifid_rt = rt;  ifa.ifid_use_rs = urs;
      ifa.ifid_use_rt = urt;  ifa.ifid_md_use = mdu;  ifa.idex_rt = xrt;
      ifa.idex_memtoreg = mem;  ifa.md_start = mds;  ifa.ex_redirect = rdr;
   endtask

   task automatic drive_b(input logic [4:0] rs, rt, input logic urs, urt, mdu,
                          input logic [4:0] xrt, input logic mem, mds, rdr);
      ifb.ifid_rs = rs;  ifb.ifid_rt = rt;  ifb.ifid_use_rs = urs;
      ifb.ifid_use_rt = urt;  ifb.ifid_md_use = mdu;  ifb.idex_rt = xrt;
      ifb.idex_memtoreg = mem;  ifb.md_start = mds;  ifb.ex_redirect = rdr;
   endtask

   // One cycle: apply inputs just after the rising edge, queue the expected response.
   task automatic vec(input bit sel, input bit rstv,
                      input logic [4:0] rs, rt, input logic urs, urt, mdu,
                      input logic [4:0] xrt, input logic mem, mds, rdr,
                      input logic [4:0] ectl, input int unsigned ecnt);
      exp_t e;
      @(posedge clk);
      #1;
      rst_n = rstv;
      if (sel) begin
         drive_b(rs, rt, urs, urt, mdu, xrt, mem, mds, rdr);
         drive_a('0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      end else begin
         drive_a(rs, rt, urs, urt, mdu, xrt, mem, mds, rdr);
         drive_b('0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      end
      e.sel = sel;
      e.id  = vid;
      e.ctl = ectl;
      e.cnt = ecnt;
      q.push_back(e);
      vid++;
   endtask

   task automatic idle(input bit sel, input logic [4:0] ectl, input int unsigned ecnt);
      vec(sel, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, ectl, ecnt);
   endtask

   // Monitor: outputs are combinational, so compare mid-cycle on the falling edge.
   initial begin
      exp_t        e;
      logic [4:0]  act;
      int unsigned acnt;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            if (e.sel) begin
               act  = {ifb.pc_stall_en, ifb.ifid_wr, ifb.idex_clear, ifb.ifid_flush, ifb.md_busy};
               acnt = 32'(ifb.stall_count);
            end else begin
               act  = {ifa.pc_stall_en, ifa.ifid_wr, ifa.idex_clear, ifa.ifid_flush, ifa.md_busy};
               acnt = 32'(ifa.stall_count);
            end
            checks++;
            if (act !== e.ctl) begin
               errors++;
               $display("FAIL ctl dut%0d vec%0d: got %b expected %b", e.sel, e.id, act, e.ctl);
            end
            checks++;
            if (acnt != e.cnt) begin
               errors++;
               $display("FAIL stall_count dut%0d vec%0d: got %0d expected %0d", e.sel, e.id, acnt, e.cnt);
            end
         end
      end
   end

   initial begin
      checks = 0;
      errors = 0;
      vid    = 0;
      rst_n  = 1'b0;
      drive_a('0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      drive_b('0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);

      // Reset state
      vec(0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_RUN, 0);
      idle(0, C_RUN, 0);

      // LOAD_LAT=3 load-use on rs, EX inputs dropped after first cycle
      vec(0, 1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, C_STL, 0);
      idle(0, C_STL, 1);
      idle(0, C_STL, 2);
      idle(0, C_RUN, 3);

      // $0 destination and unused-operand match never stall
      vec(0, 1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, C_RUN, 3);
      vec(0, 1'b1, 5'd8, 5'd8, 1'b0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, C_RUN, 3);

      // rt hazard, then redirect in the second stall cycle
      vec(0, 1'b1, 5'd3, 5'd9, 1'b1, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, C_STL, 3);
      vec(0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, C_RDR, 4);
      idle(0, C_RUN, 4);

      // Mult/div: start at t, use from t+1, restart at t+2 extends to t+6
      vec(0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_RUN, 4);
      vec(0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, C_STLB, 4);
      vec(0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, C_STLB, 5);
      vec(0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, C_STLB, 6);
      vec(0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, C_STLB, 7);
      vec(0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, C_STLB, 8);
      vec(0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, C_STLB, 9);
      vec(0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, C_RUN, 10);

      // md_start with redirect: both honoured; redirect masks a later md_hit
      vec(0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, C_RDR, 10);
      idle(0, C_RUNB, 10);
      vec(0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, C_RDRB, 10);

      // Async reset while in LSTALL with md_busy set
      vec(0, 1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, C_STLB, 10);
      vec(0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_RUN, 0);
      idle(0, C_RUN, 0);

      // Continuous load-use for 21 stall cycles: counter saturates at 15
      for (int k = 0; k < 20; k++)
         vec(0, 1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, C_STL,
             (k < 15) ? 32'(k) : 32'd15);
      idle(0, C_STL, 15);
      idle(0, C_RUN, 15);

      // LOAD_LAT=1 instance: single bubble, back-to-back hazards
      idle(1, C_RUN, 0);
      vec(1, 1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, C_STL, 0);
      idle(1, C_RUN, 1);
      vec(1, 1'b1, 5'd1, 5'd7, 1'b1, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, C_STL, 1);
      vec(1, 1'b1, 5'd7, 5'd2, 1'b1, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, C_STL, 2);
      idle(1, C_RUN, 3);

      for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
      #1;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected responses never compared, required 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
